// File: rtl/lfsr_seq_gen.sv
// Galois LFSR sequence generator with seed load, mark/rewind checkpoint,
// saturating steps-since-mark counter and period-complete detection.
module lfsr_seq_gen #(
  parameter int unsigned           WIDTH      = 8,
  parameter logic [WIDTH-1:0]      TAPS       = 8'hB8,
  parameter int unsigned           SYM_BITS   = 2,
  parameter logic [WIDTH-1:0]      RESET_SEED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [WIDTH-1:0]    seed,
  input  logic                seed_load,
  input  logic                step,
  input  logic                mark,
  input  logic                rewind,
  output logic [WIDTH-1:0]    lfsr_out,
  output logic [SYM_BITS-1:0] sym_out,
  output logic [WIDTH-1:0]    steps_since_mark,
  output logic                period_done,
  output logic                wrapped
);

  logic [WIDTH-1:0] state_q, seed_q, mark_q, count_q;
  logic             period_done_q, wrapped_q;
  logic [WIDTH-1:0] nxt, load_val, count_inc;

  always_comb begin
    nxt       = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    // An all-zero state would lock the LFSR, so a zero seed loads 1 instead.
    load_val  = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
    count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_SEED;
      seed_q        <= RESET_SEED;
      mark_q        <= RESET_SEED;
      count_q       <= '0;
      period_done_q <= 1'b0;
      wrapped_q     <= 1'b0;
    end else if (!enable) begin
      period_done_q <= 1'b0;
    end else begin
      period_done_q <= 1'b0;
      if (seed_load) begin
        state_q   <= load_val;
        seed_q    <= load_val;
        mark_q    <= load_val;
        count_q   <= '0;
        wrapped_q <= 1'b0;
      end else if (rewind) begin
        state_q <= mark_q;
        count_q <= '0;
      end else begin
        if (step) begin
          state_q <= nxt;
          // A mark in the same cycle checkpoints the pre-step state, so one step is counted.
          count_q <= mark ? {{(WIDTH-1){1'b0}}, 1'b1} : count_inc;
          if (nxt == seed_q) begin
            period_done_q <= 1'b1;
            wrapped_q     <= 1'b1;
          end
        end else if (mark) begin
          count_q <= '0;
        end
        if (mark) mark_q <= state_q;
      end
    end
  end

  assign lfsr_out         = state_q;
  assign sym_out          = state_q[SYM_BITS-1:0];
  assign steps_since_mark = count_q;
  assign period_done      = period_done_q;
  assign wrapped          = wrapped_q;

endmodule

// File: doc/lfsr_seq_gen.md
Name: lfsr_seq_gen

Overview:
Parametrised successor to the game's fixed 8-bit LFSR. It is a Galois LFSR with configurable width, tap mask and symbol size, stepped by an explicit request. It adds seed loading with a zero-seed guard, a mark/rewind checkpoint so the Simon Says controller can replay the same colour sequence, a steps-since-mark counter, and period-complete detection. It sits between the top-level seed inputs and the game FSM, which consumes sym_out one symbol per step.

Parameters:
WIDTH, 8, LFSR state width in bits (min 3).
TAPS, 8'hB8, Galois feedback mask XORed into the right-shifted state when the shifted-out bit is 1. The default is maximal length for WIDTH=8 (period 255).
SYM_BITS, 2, width of the symbol output taken from the state LSBs (must be <= WIDTH).
RESET_SEED, 1, state, seed and mark value after reset (nonzero).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  global enable; when low, all commands are ignored and state holds
seed  input  WIDTH  seed value for seed_load
seed_load  input  1  load seed into state, seed register and mark register
step  input  1  advance the LFSR one position
mark  input  1  checkpoint current state into mark register
rewind  input  1  restore state from mark register
lfsr_out  output  WIDTH  current LFSR state (registered)
sym_out  output  SYM_BITS  lfsr_out[SYM_BITS-1:0]
steps_since_mark  output  WIDTH  steps taken since the last mark, rewind or load; saturating
period_done  output  1  one-cycle pulse: state returned to the loaded seed
wrapped  output  1  sticky: period_done has fired since the last load or reset

Behaviour:
- Reset (async, rst=1):
  - lfsr_out, seed_reg and mark_reg = RESET_SEED.
  - steps_since_mark = 0; period_done = 0; wrapped = 0.
- Step function (nxt): if state[0]=1 then (state>>1) ^ TAPS, else state>>1.
- Command priority per cycle, only when enable=1: seed_load > rewind > step. mark is independent but suppressed by seed_load or rewind.
- seed_load:
  - Loaded value is seed, or 1 if seed==0 (zero-lockup guard).
  - That value goes into state, seed_reg and mark_reg.
  - Count = 0; wrapped = 0; period_done = 0 next cycle.
  - step, rewind and mark in the same cycle are ignored.
- rewind: state = mark_reg; count = 0; step in the same cycle is ignored; no period_done.
- step: state = nxt. Count increments, saturating at 2^WIDTH-1. If nxt == seed_reg, period_done = 1 next cycle and wrapped is set.
- mark (no load or rewind): mark_reg = current pre-update state.
  - mark with step: count = 1.
  - mark without step: count = 0.
- Latency: every output reflects a command one cycle after the sampling edge. sym_out is a combinational slice of registered state.
- period_done is high for exactly one cycle per return. Back-to-back steps may produce consecutive pulses only when the period is 1 (not reachable with a nonzero maximal mask).
- enable=0: all registers hold; period_done drops to 0.
- Reset asserted mid-sequence clears immediately, without waiting for a clock edge. The first command after release is honoured on the first rising edge.

Test Plan:
1. Reset then 5 steps (defaults) -> lfsr_out 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3; sym_out 1,0,0,2,3,3; steps_since_mark 0..5.
2. seed_load with seed=0x00 -> lfsr_out=0x01, wrapped=0. seed_load with seed=0xA5, then 255 steps -> period_done pulses exactly once, on the cycle after step 255; lfsr_out=0xA5; wrapped=1; steps_since_mark=255 saturated. One more step -> no pulse, count stays 255.
3. Seed 0x01, 2 steps, mark, 3 steps, rewind -> lfsr_out=0x5C, count 0. Next 3 steps reproduce 0x2E, 0x17, 0xB3.
4. Simultaneous events:
   - mark+step at state 0x5C -> mark_reg=0x5C, state=0x2E, count=1.
   - rewind+step -> state=mark_reg, count 0.
   - seed_load+rewind+step -> seed wins.
5. enable=0 with step held for 10 cycles -> all outputs unchanged, period_done=0. Re-enable -> stepping resumes from the held state.
6. Assert rst asynchronously between edges during stepping -> outputs return to reset values before the next edge. Separately, with WIDTH=4, TAPS=4'hC, seed 1 -> period_done after 15 steps.
